gate_bist_ctrl: RTL and testbench

- Sequential stimulus/response driver for the 12-input / 10-output combinational gate models in the simulator gate library.
- Generates pseudo-random 12-bit input vectors with an LFSR and drives them onto the gate model inputs N1..N12.
- Waits a programmable settle time, then compacts the model's 10 outputs into a 16-bit MISR signature.
- At end of run, compares the signature against a golden value; used by the lab's self-test bench to screen every gate-model variant.

---
 rtl/gate_bist_ctrl_if.sv | 47 ++++
 rtl/gate_bist_ctrl.sv | 152 +++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_bist_ctrl_if.sv
// gate_bist_ctrl_if: control/response bundle between a self-test host and
// gate_bist_ctrl.
//
// Signals:
//   start      host -> ctrl  begin a run (level, sampled only when idle/done)
//   abort      host -> ctrl  stop a running test (WAIT/CAPTURE only)
//   golden_sig host -> ctrl  expected final signature
//   dut_out    host -> ctrl  gate-model outputs, bit0 = first listed output
//   dut_in     ctrl -> host  vector to the gate model, bit0 drives N1
//   busy       ctrl -> host  run in progress
//   done       ctrl -> host  run complete, held until the next start
//   pass       ctrl -> host  final signature matched golden_sig (valid with done)
//   signature  ctrl -> host  current MISR value
//   pat_cnt    ctrl -> host  patterns captured so far
//   state_dbg  ctrl -> host  FSM state for observation
//
// Handshake: there is no ready/valid pair. start acts as a request that is
// accepted on any edge where the controller is idle or done; acceptance is
// seen one cycle later as busy=1. done=1 with busy=0 marks a completed run,
// and pass is only meaningful while done=1. abort is honoured only while
// busy=1.
interface gate_bist_ctrl_if #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 10
);
   logic             start;
   logic             abort;
   logic [15:0]      golden_sig;
   logic [OUT_W-1:0] dut_out;
   logic [IN_W-1:0]  dut_in;
   logic             busy;
   logic             done;
   logic             pass;
   logic [15:0]      signature;
   logic [11:0]      pat_cnt;
   logic [1:0]       state_dbg;

   modport master (
      output start, abort, golden_sig, dut_out,
      input  dut_in, busy, done, pass, signature, pat_cnt, state_dbg
   );

   modport slave (
      input  start, abort, golden_sig, dut_out,
      output dut_in, busy, done, pass, signature, pat_cnt, state_dbg
   );
endinterface

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: stimulus/response driver for the 12-in / 10-out gate models.
// An LFSR drives pseudo-random vectors onto the model, each vector is held
// for SETTLE cycles, then the model outputs are folded into a 16-bit MISR.
// After PATTERNS captures the signature is compared with golden_sig.
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    gate_bist_ctrl_if.slave (start/abort/golden_sig/dut_out in,
//          dut_in/busy/done/pass/signature/pat_cnt/state_dbg out)
//
// start is registered: the edge that samples start clears the run state and
// reloads the seed, and the run itself (busy=1) begins on the following edge.
// That keeps done landing PATTERNS*(SETTLE+1)+1 edges after the start edge.
module gate_bist_ctrl #(
   parameter int              IN_W     = 12,
   parameter int              OUT_W    = 10,
   parameter int              PATTERNS = 256,
   parameter int              SETTLE   = 2,
   parameter logic [IN_W-1:0] SEED     = 12'h001
) (
   input  logic              clk,
   input  logic              rst_n,
   gate_bist_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [IN_W-1:0] SEED_EFF =
      (SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : SEED;
   localparam logic [11:0] PAT_LAST = 12'(PATTERNS);
   localparam logic [3:0]  SETTLE_W = 4'(SETTLE);

   state_t          state;
   logic            arm;       // start accepted, run begins next edge
   logic [3:0]      wait_cnt;  // WAIT cycles remaining minus one
   logic [IN_W-1:0] lfsr;
   logic [15:0]     signature;
   logic [11:0]     pat_cnt;
   logic            busy;
   logic            done;
   logic            pass;

   logic [IN_W-1:0] lfsr_next;
   logic [15:0]     sig_next;
   logic [15:0]     out_ext;
   logic [11:0]     pat_next;

   // x^12+x^6+x^4+x+1 Fibonacci LFSR; Galois MISR with poly 0x1021.
   always_comb begin
      lfsr_next = {lfsr[IN_W-2:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
      out_ext = '0;
      out_ext[OUT_W-1:0] = bus.dut_out;
      sig_next = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000)
                 ^ out_ext;
      pat_next = pat_cnt + 12'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         arm       <= 1'b0;
         wait_cnt  <= 4'd0;
         lfsr      <= SEED_EFF;
         signature <= 16'h0000;
         pat_cnt   <= 12'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  arm  <= 1'b0;
                  busy <= 1'b1;
                  if (SETTLE == 0) begin
                     state <= S_CAPTURE;
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= SETTLE_W - 4'd1;
                  end
               end else if (bus.start) begin
                  // start has priority over abort here; abort is ignored
                  // outside a run anyway.
                  arm       <= 1'b1;
                  state     <= S_IDLE;
                  lfsr      <= SEED_EFF;
                  signature <= 16'h0000;
                  pat_cnt   <= 12'd0;
                  done      <= 1'b0;
                  pass      <= 1'b0;
               end
            end

            S_WAIT: begin
               if (bus.abort) begin
                  // signature, pat_cnt and dut_in stay frozen for debug
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
                  pass  <= 1'b0;
               end else if (wait_cnt == 4'd0) begin
                  state <= S_CAPTURE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            S_CAPTURE: begin
               if (bus.abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
                  pass  <= 1'b0;
               end else begin
                  signature <= sig_next;
                  lfsr      <= lfsr_next;
                  pat_cnt   <= pat_next;
                  if (pat_next == PAT_LAST) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (sig_next == bus.golden_sig);
                  end else if (SETTLE == 0) begin
                     state <= S_CAPTURE;
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= SETTLE_W - 4'd1;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.dut_in    = lfsr;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.pass      = pass;
   assign bus.signature = signature;
   assign bus.pat_cnt   = pat_cnt;
   assign bus.state_dbg = state;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: five instances with different PATTERNS/SETTLE,
// a time-based reference model, a per-cycle compare process, a done-edge
// signature scoreboard and directed hand-computed checks.
module tb_gate_bist_ctrl;

   localparam int NI   = 5;
   localparam int MAXP = 8;
   localparam int P_TAB [NI] = '{3, 2, 4, 1, 8};
   localparam int S_TAB [NI] = '{0, 0, 2, 1, 2};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus and observed outputs ----------------
   logic [NI-1:0]        start_v;
   logic [NI-1:0]        abort_v;
   logic [NI-1:0]        ident_v;   // 1: dut_out loops back dut_in[9:0]
   logic [NI-1:0][9:0]   outv_v;    // constant dut_out otherwise
   logic [NI-1:0][15:0]  gold_v;
   logic [NI-1:0][11:0]  din_v;
   logic [NI-1:0]        busy_v;
   logic [NI-1:0]        done_v;
   logic [NI-1:0]        pass_v;
   logic [NI-1:0][15:0]  sig_v;
   logic [NI-1:0][11:0]  pc_v;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      gate_bist_ctrl_if #(.IN_W(12), .OUT_W(10)) bus ();
      assign bus.start      = start_v[g];
      assign bus.abort      = abort_v[g];
      assign bus.golden_sig = gold_v[g];
      assign bus.dut_out    = ident_v[g] ? bus.dut_in[9:0] : outv_v[g];
      assign din_v[g]  = bus.dut_in;
      assign busy_v[g] = bus.busy;
      assign done_v[g] = bus.done;
      assign pass_v[g] = bus.pass;
      assign sig_v[g]  = bus.signature;
      assign pc_v[g]   = bus.pat_cnt;

      gate_bist_ctrl #(
         .IN_W(12), .OUT_W(10), .PATTERNS(P_TAB[g]), .SETTLE(S_TAB[g]),
         .SEED(12'h001)
      ) dut (
         .clk(clk),
         .rst_n(rst_n),
         .bus(bus)
      );
   end

   // ---------------- counters and check helper ----------------
   int n_chk = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input int idx,
                        input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] t=%0t got %h want %h", name, idx, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [11:0] lfsr_step(input logic [11:0] q);
      return {q[10:0], q[11] ^ q[5] ^ q[3] ^ q[0]};
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [9:0] r);
      logic [15:0] t;
      t = {s[14:0], 1'b0};
      if (s[15]) t = t ^ 16'h1021;
      return t ^ {6'b0, r};
   endfunction

   // Per run the model precomputes vector j and signature after j captures,
   // then derives every output from the number of edges since start.
   logic [11:0] m_vec [NI][MAXP+1];
   logic [15:0] m_sig [NI][MAXP+1];
   logic        m_run [NI];
   int          m_k   [NI];
   int          edge_n = 0;

   logic [11:0] e_din  [NI];
   logic [15:0] e_sig  [NI];
   logic [11:0] e_pc   [NI];
   logic        e_busy [NI];
   logic        e_done [NI];
   logic        e_pass [NI];

   logic [15:0] exp_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) begin
            m_run[i]  = 1'b0;
            e_din[i]  = 12'h001;
            e_sig[i]  = 16'h0000;
            e_pc[i]   = 12'd0;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
            e_pass[i] = 1'b0;
         end
      end else begin
         edge_n++;
         for (int i = 0; i < NI; i++) begin
            if (m_run[i] && e_busy[i] && abort_v[i]) begin
               m_run[i]  = 1'b0;
               e_busy[i] = 1'b0;
               e_done[i] = 1'b0;
               e_pass[i] = 1'b0;
            end else if ((!m_run[i] || e_done[i]) && start_v[i]) begin
               m_run[i] = 1'b1;
               m_k[i]   = edge_n;
               m_vec[i][0] = 12'h001;
               m_sig[i][0] = 16'h0000;
               for (int j = 0; j < P_TAB[i]; j++) begin
                  logic [9:0] r;
                  r = ident_v[i] ? m_vec[i][j][9:0] : outv_v[i];
                  m_sig[i][j+1] = misr_step(m_sig[i][j], r);
                  m_vec[i][j+1] = lfsr_step(m_vec[i][j]);
               end
               e_din[i]  = 12'h001;
               e_sig[i]  = 16'h0000;
               e_pc[i]   = 12'd0;
               e_busy[i] = 1'b0;
               e_done[i] = 1'b0;
               e_pass[i] = 1'b0;
            end else if (m_run[i]) begin
               int c;
               c = (edge_n - m_k[i] - 1) / (S_TAB[i] + 1);
               if (c > P_TAB[i]) c = P_TAB[i];
               e_din[i]  = m_vec[i][c];
               e_sig[i]  = m_sig[i][c];
               e_pc[i]   = 12'(c);
               e_busy[i] = (c < P_TAB[i]);
               if (c == P_TAB[i] && !e_done[i]) begin
                  e_done[i] = 1'b1;
                  e_pass[i] = (m_sig[i][c] == gold_v[i]);
                  exp_q.push_back(m_sig[i][c]);
               end
            end
         end
      end
   end

   // ---------------- compare process + done scoreboard ----------------
   logic [NI-1:0] prev_done = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            check("dut_in",    i, 16'(din_v[i]),  16'(e_din[i]));
            check("signature", i, sig_v[i],       e_sig[i]);
            check("pat_cnt",   i, 16'(pc_v[i]),   16'(e_pc[i]));
            check("busy",      i, 16'(busy_v[i]), 16'(e_busy[i]));
            check("done",      i, 16'(done_v[i]), 16'(e_done[i]));
            check("pass",      i, 16'(pass_v[i]), 16'(e_pass[i]));
            if (done_v[i] && !prev_done[i]) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL sb_unexpected_done[%0d] got sig %h want no done", i, sig_v[i]);
               end else begin
                  logic [15:0] exp_sig;
                  exp_sig = exp_q.pop_front();
                  check("sb_final_sig", i, sig_v[i], exp_sig);
               end
            end
            prev_done[i] = done_v[i];
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input int i);
      @(negedge clk); #1 start_v[i] = 1'b1;
      @(negedge clk); #1 start_v[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int budget);
      int n;
      n = 0;
      while (!done_v[i] && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1 check("done_within_budget", i, 16'(done_v[i]), 16'd1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      start_v = '0;
      abort_v = '0;
      ident_v = 5'b10001;
      outv_v[0] = 10'h000; gold_v[0] = 16'h0005;
      outv_v[1] = 10'h001; gold_v[1] = 16'h0003;
      outv_v[2] = 10'h000; gold_v[2] = 16'h0000;
      outv_v[3] = 10'h3FF; gold_v[3] = 16'h03FF;
      outv_v[4] = 10'h000; gold_v[4] = 16'h0055;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      check("rst_din",  0, 16'(din_v[0]),  16'h0001);
      check("rst_sig",  0, sig_v[0],       16'h0000);
      check("rst_pc",   0, 16'(pc_v[0]),   16'h0000);
      check("rst_busy", 0, 16'(busy_v[0]), 16'd0);
      check("rst_done", 0, 16'(done_v[0]), 16'd0);
      check("rst_pass", 0, 16'(pass_v[0]), 16'd0);

      // P=3, S=0, identity loop-back
      pulse_start(0);
      @(negedge clk);
      check("t1_din_a", 0, 16'(din_v[0]), 16'h0001);
      check("t1_busy",  0, 16'(busy_v[0]), 16'd1);
      @(negedge clk);
      check("t1_sig_a", 0, sig_v[0], 16'h0001);
      check("t1_din_b", 0, 16'(din_v[0]), 16'h0003);
      @(negedge clk);
      check("t1_sig_b", 0, sig_v[0], 16'h0001);
      check("t1_din_c", 0, 16'(din_v[0]), 16'h0007);
      check("t1_not_done", 0, 16'(done_v[0]), 16'd0);
      @(negedge clk);
      check("t1_sig_c", 0, sig_v[0], 16'h0005);
      check("t1_done",  0, 16'(done_v[0]), 16'd1);
      check("t1_pc",    0, 16'(pc_v[0]), 16'd3);
      check("t1_pass",  0, 16'(pass_v[0]), 16'd1);

      // P=2, S=0, dut_out=001, golden 0003 then 0004
      pulse_start(1);
      @(negedge clk);
      @(negedge clk);
      check("t2_sig_a", 1, sig_v[1], 16'h0001);
      @(negedge clk);
      check("t2_sig_b", 1, sig_v[1], 16'h0003);
      check("t2_pass",  1, 16'(pass_v[1]), 16'd1);
      #1 gold_v[1] = 16'h0004;
      pulse_start(1);
      repeat (3) @(negedge clk);
      check("t2_done2", 1, 16'(done_v[1]), 16'd1);
      check("t2_fail2", 1, 16'(pass_v[1]), 16'd0);

      // P=4, S=2, dut_out=0: 12 busy cycles, done 13 edges after start
      begin
         int busy_cnt;
         int done_at;
         busy_cnt = 0;
         done_at  = 0;
         pulse_start(2);
         for (int n = 1; n <= 40 && done_at == 0; n++) begin
            @(negedge clk);
            if (busy_v[2]) busy_cnt++;
            if (done_v[2]) done_at = n;
         end
         check("t3_busy_cycles", 2, 16'(busy_cnt), 16'd12);
         check("t3_done_edge",   2, 16'(done_at),  16'd13);
         check("t3_sig",         2, sig_v[2],      16'h0000);
         check("t3_pc",          2, 16'(pc_v[2]),  16'd4);
      end

      // P=1, S=1, dut_out=3FF; start pulsed while busy is ignored
      pulse_start(3);
      @(negedge clk);
      check("t4_busy", 3, 16'(busy_v[3]), 16'd1);
      #1 start_v[3] = 1'b1;
      @(negedge clk);
      #1 start_v[3] = 1'b0;
      wait_done(3, 10);
      check("t4_sig",  3, sig_v[3], 16'h03FF);
      check("t4_pc",   3, 16'(pc_v[3]), 16'd1);
      check("t4_pass", 3, 16'(pass_v[3]), 16'd1);
      repeat (3) @(negedge clk);
      check("t4_done_held", 3, 16'(done_v[3]), 16'd1);

      // P=8, S=2, identity: abort in the second WAIT
      pulse_start(4);
      repeat (4) @(negedge clk);
      check("t5_pc_before", 4, 16'(pc_v[4]), 16'd1);
      check("t5_busy_before", 4, 16'(busy_v[4]), 16'd1);
      #1 abort_v[4] = 1'b1;
      @(negedge clk);
      #1 abort_v[4] = 1'b0;
      check("t5_busy_after", 4, 16'(busy_v[4]), 16'd0);
      check("t5_done_after", 4, 16'(done_v[4]), 16'd0);
      check("t5_pc_frozen",  4, 16'(pc_v[4]),   16'd1);
      check("t5_sig_frozen", 4, sig_v[4],       16'h0001);
      repeat (2) @(negedge clk);
      check("t5_pc_still", 4, 16'(pc_v[4]), 16'd1);

      // restart, then reset during the second CAPTURE
      pulse_start(4);
      check("t6_restart_sig", 4, sig_v[4], 16'h0000);
      check("t6_restart_din", 4, 16'(din_v[4]), 16'h0001);
      repeat (6) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_din",  4, 16'(din_v[4]),  16'h0001);
      check("t6_rst_sig",  4, sig_v[4],       16'h0000);
      check("t6_rst_pc",   4, 16'(pc_v[4]),   16'd0);
      check("t6_rst_busy", 4, 16'(busy_v[4]), 16'd0);
      check("t6_rst_done", 4, 16'(done_v[4]), 16'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // full run after reset matches the golden run
      pulse_start(4);
      wait_done(4, 40);
      check("t6_final_sig",  4, sig_v[4], 16'h0055);
      check("t6_final_pc",   4, 16'(pc_v[4]), 16'd8);
      check("t6_final_pass", 4, 16'(pass_v[4]), 16'd1);

      repeat (2) @(negedge clk);
      #1 check("sb_queue_drained", 0, 16'(exp_q.size()), 16'd0);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
